risc_register_file: RTL and testbench
=====================================

# risc_register_file

Architectural register file (x0–x31) for the RISC-V core, directly upstream of `risc_instructions_handler_2`.
- Serves its two operand-read ports (`reg_rd_addr_a/b`, `_valid`, `_ack`) with a valid/ack handshake.
- Accepts result write-back from the ALU.
- Holds a per-register busy scoreboard so a read of a register with an in-flight result stalls until that result is written, with write-to-read bypass.

## Interface
Parameters:
- `XLEN`, 32, register data width
- `NUM_REGS`, 32, number of architectural registers (x0 hardwired zero)
- `ADDR_W`, 5, register address width, equal to clog2(`NUM_REGS`)

Ports (clock `clk`; reset `reset`, synchronous, active-high):
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `rd_addr_a`  in  ADDR_W  port A read address; held stable while `rd_addr_a_valid`=1
- `rd_addr_a_valid`  in  1  port A request
- `rd_data_a`  out  XLEN  port A read data; valid only while `rd_data_a_ack`=1
- `rd_data_a_ack`  out  1  port A acknowledge, one-cycle pulse
- `rd_addr_b`, `rd_addr_b_valid`, `rd_data_b`, `rd_data_b_ack`: port B, identical to port A
- `wr_addr`  in  ADDR_W  write-back destination
- `wr_data`  in  XLEN  write-back data
- `wr_valid`  in  1  single-cycle write strobe; always accepted, no ack
- `reserve_addr`  in  ADDR_W  destination of an instruction just issued to the ALU
- `reserve_valid`  in  1  single-cycle strobe; sets the busy bit of `reserve_addr`
- `busy_vec`  out  NUM_REGS  current scoreboard, for debug and verification

## Operation
- Storage is `NUM_REGS` × `XLEN` flops. Reads of x0 return 0. Writes and reserves to x0 are ignored, so `busy_vec[0]` is always 0.
- Write: on `wr_valid`, `regs[wr_addr]` ← `wr_data` and `busy[wr_addr]` ← 0.
- Reserve: on `reserve_valid`, `busy[reserve_addr]` ← 1.
- Write and reserve to the same address in the same cycle: data is written and busy ends at 1 (the new instruction owns the register).
- Read FSM, shared by both ports so the two acks align. States: `RF_IDLE`, `RF_STALL`, `RF_ACK`.
  - `RF_IDLE`: when either valid is 1, latch the request mask {a,b} and both addresses.
    - If no requested register is blocked, go to `RF_ACK`. Otherwise go to `RF_STALL`.
    - A register is blocked if busy=1 and it is not being written this cycle.
  - `RF_STALL`: re-evaluate each cycle using the latched mask and addresses. Go to `RF_ACK` once all requested registers are unblocked.
  - `RF_ACK`: the ack of every masked port is 1 for exactly this cycle, with data driven. Next state is always `RF_IDLE`. Valids seen during this state are ignored, because the requester is still dropping them.
- Data captured on the transition into `RF_ACK` uses this priority:
  1. 0 if address is 0;
  2. `wr_data` if `wr_valid` and `wr_addr` match this cycle (bypass);
  3. otherwise `regs[addr]`.
- A request on one port only acks that port. The other port's ack stays 0 and its data is unchanged.
- Requester rule: keep valid and address stable until ack. Drop valid on the edge that samples ack. Do not re-request in the cycle after ack.

## Timing
- Reset values:
  - all `regs` = 0, `busy` = 0, `busy_vec` = 0
  - FSM = `RF_IDLE`
  - `rd_data_a` = `rd_data_b` = 0, `rd_data_a_ack` = `rd_data_b_ack` = 0
- Reset during `RF_STALL` or `RF_ACK`: the pending request is dropped and no ack is issued afterwards.
- Unblocked read: valid sampled at edge N gives ack and data high in cycle N+1 (one-cycle latency). Peak throughput is one read transaction every 2 cycles.
- Blocked read: a matching write sampled at edge M gives ack in cycle M+1, carrying `wr_data`. This holds even if the write lands at the same edge the request is first sampled.
- A reserve at edge N affects requests evaluated at edge N+1 onward. A request and a reserve on the same edge see the old busy state.
- A write is visible in `regs` from cycle N+1. `busy_vec` is registered and updates one cycle after the strobe.
- No timeout: a stall with no matching write holds forever. That is a protocol error and is flagged by an assertion in the bench.

## Structure
- Shared package `risc_pkg`:
  - `XLEN` and `REG_ADDR_W` constants
  - `rf_state_t` enum {`RF_IDLE`, `RF_STALL`, `RF_ACK`}
  - `RISC_INSTR_TYPE` (moved from the handler)
- Sub-module `risc_reg_scoreboard`: the busy vector with set/clear/priority logic and combinational `blocked(addr, wr_valid, wr_addr)` outputs for two query ports.
- Storage and the read FSM stay in the top module.

## Test plan
- Reset, write x5=0x0000_1234, then request A=x5 and B=x0 together → both acks in the same cycle, one cycle later; A=0x1234, B=0.
- Write x0=0xFFFF_FFFF, then read x0 → data 0 and `busy_vec[0]`=0.
- Reserve x7, request A=x7 and B=x3 (x3=0x55); 3 cycles later write x7=0xABCD → no ack before the write; both acks the cycle after the write edge; A=0xABCD, B=0x55.
- Request A=x9 only while x9 is busy, with `wr_valid` x9=0x77 on the same edge → ack A in the next cycle with 0x77; `rd_data_b_ack` stays 0.
- Reserve and write x4=0x11 on the same edge → `busy_vec[4]`=1 afterward; a subsequent read of x4 stalls until the next write of x4.
- Assert reset during `RF_STALL` → no ack afterward, `busy_vec`=0, all registers read as 0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC-V core: register file widths,
// register-file read FSM states and the instruction class enumeration.
package risc_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Read FSM shared by both operand ports of the register file.
   typedef enum logic [1:0] {
      RF_IDLE  = 2'd0,
      RF_STALL = 2'd1,
      RF_ACK   = 2'd2
   } rf_state_t;

   // Instruction classes decoded by the instruction handler.
   typedef enum logic [2:0] {
      INSTR_ALU_REG = 3'd0,
      INSTR_ALU_IMM = 3'd1,
      INSTR_LOAD    = 3'd2,
      INSTR_STORE   = 3'd3,
      INSTR_BRANCH  = 3'd4,
      INSTR_JUMP    = 3'd5,
      INSTR_UPPER   = 3'd6,
      INSTR_INVALID = 3'd7
   } RISC_INSTR_TYPE;

endpackage

// File: rtl/risc_reg_scoreboard.sv
// Per-register busy scoreboard. A reserve marks a destination as owned by an
// in-flight instruction, a write-back releases it. Two combinational query
// ports report whether a register is still blocked this cycle, treating a
// write landing in the same cycle as already released (write-to-read bypass).
module risc_reg_scoreboard
   import risc_pkg::*;
#(
   parameter int NUM_REGS = risc_pkg::NUM_REGS,
   parameter int ADDR_W   = risc_pkg::REG_ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_valid,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                reserve_valid,
   input  logic [ADDR_W-1:0]   reserve_addr,
   input  logic [ADDR_W-1:0]   query_a_addr,
   input  logic [ADDR_W-1:0]   query_b_addr,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                blocked_a,
   output logic                blocked_b
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Next busy vector: clear on write-back, then set on reserve so a
   // same-cycle reserve wins; x0 can never be busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_valid) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (reserve_valid) begin
         busy_d[reserve_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Blocked queries use the current (pre-reserve) busy state so a request and
   // a reserve on the same edge see the old value.
   always_comb begin
      blocked_a = busy_q[query_a_addr] && !(wr_valid && (wr_addr == query_a_addr));
      blocked_b = busy_q[query_b_addr] && !(wr_valid && (wr_addr == query_b_addr));
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/risc_register_file.sv
// Architectural register file x0..x31 with two operand read ports sharing one
// read FSM (so the acks of a dual request align), ALU write-back, and a busy
// scoreboard that stalls reads of registers with an in-flight result.
// Handshake: a requester raises rd_addr_*_valid with a stable address and keeps
// both until the cycle rd_data_*_ack is high; ack is a one-cycle pulse with
// rd_data_* valid in that cycle. Valids seen while acking are ignored.
module risc_register_file #(
   parameter int XLEN     = risc_pkg::XLEN,
   parameter int NUM_REGS = risc_pkg::NUM_REGS,
   parameter int ADDR_W   = risc_pkg::REG_ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   input  logic                rd_addr_a_valid,
   output logic [XLEN-1:0]     rd_data_a,
   output logic                rd_data_a_ack,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   input  logic                rd_addr_b_valid,
   output logic [XLEN-1:0]     rd_data_b,
   output logic                rd_data_b_ack,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                wr_valid,
   input  logic [ADDR_W-1:0]   reserve_addr,
   input  logic                reserve_valid,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [1:0]          rf_state_dbg
);

   import risc_pkg::*;

   logic [XLEN-1:0]   regs_q [NUM_REGS];
   rf_state_t         state_q;
   logic              mask_a_q, mask_b_q;
   logic [ADDR_W-1:0] addr_a_q, addr_b_q;
   logic [XLEN-1:0]   rd_data_a_q, rd_data_b_q;
   logic              ack_a_q, ack_b_q;

   logic              in_idle;
   logic              req_a, req_b;
   logic [ADDR_W-1:0] q_addr_a, q_addr_b;
   logic              blocked_a, blocked_b;
   logic              any_blocked;
   logic [XLEN-1:0]   rd_val_a, rd_val_b;

   // In IDLE the live request is evaluated; afterwards the latched one.
   always_comb begin
      in_idle     = (state_q == RF_IDLE);
      req_a       = in_idle ? rd_addr_a_valid : mask_a_q;
      req_b       = in_idle ? rd_addr_b_valid : mask_b_q;
      q_addr_a    = in_idle ? rd_addr_a : addr_a_q;
      q_addr_b    = in_idle ? rd_addr_b : addr_b_q;
      any_blocked = (req_a && blocked_a) || (req_b && blocked_b);
   end

   risc_reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_addr       (wr_addr),
      .reserve_valid (reserve_valid),
      .reserve_addr  (reserve_addr),
      .query_a_addr  (q_addr_a),
      .query_b_addr  (q_addr_b),
      .busy_vec      (busy_vec),
      .blocked_a     (blocked_a),
      .blocked_b     (blocked_b)
   );

   // Read value per port: x0 is zero, then same-cycle write bypass, then storage.
   always_comb begin
      rd_val_a = regs_q[q_addr_a];
      if (q_addr_a == '0) begin
         rd_val_a = '0;
      end else if (wr_valid && (wr_addr == q_addr_a)) begin
         rd_val_a = wr_data;
      end
      rd_val_b = regs_q[q_addr_b];
      if (q_addr_b == '0) begin
         rd_val_b = '0;
      end else if (wr_valid && (wr_addr == q_addr_b)) begin
         rd_val_b = wr_data;
      end
   end

   // Register storage; writes to x0 are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_valid && (wr_addr != '0)) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   // Shared read FSM: latch request, stall while blocked, pulse acks with data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RF_IDLE;
         mask_a_q    <= 1'b0;
         mask_b_q    <= 1'b0;
         addr_a_q    <= '0;
         addr_b_q    <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         ack_a_q     <= 1'b0;
         ack_b_q     <= 1'b0;
      end else begin
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         case (state_q)
            RF_IDLE: begin
               if (rd_addr_a_valid || rd_addr_b_valid) begin
                  mask_a_q <= rd_addr_a_valid;
                  mask_b_q <= rd_addr_b_valid;
                  addr_a_q <= rd_addr_a;
                  addr_b_q <= rd_addr_b;
                  if (any_blocked) begin
                     state_q <= RF_STALL;
                  end else begin
                     state_q <= RF_ACK;
                     ack_a_q <= req_a;
                     ack_b_q <= req_b;
                     if (req_a) rd_data_a_q <= rd_val_a;
                     if (req_b) rd_data_b_q <= rd_val_b;
                  end
               end
            end
            RF_STALL: begin
               if (!any_blocked) begin
                  state_q <= RF_ACK;
                  ack_a_q <= req_a;
                  ack_b_q <= req_b;
                  if (req_a) rd_data_a_q <= rd_val_a;
                  if (req_b) rd_data_b_q <= rd_val_b;
               end
            end
            RF_ACK: begin
               state_q  <= RF_IDLE;
               mask_a_q <= 1'b0;
               mask_b_q <= 1'b0;
            end
            default: begin
               state_q <= RF_IDLE;
            end
         endcase
      end
   end

   assign rd_data_a     = rd_data_a_q;
   assign rd_data_b     = rd_data_b_q;
   assign rd_data_a_ack = ack_a_q;
   assign rd_data_b_ack = ack_b_q;
   assign rf_state_dbg  = state_q;

endmodule

// File: tb/tb_risc_register_file.sv
// Self-checking bench for risc_register_file: reference register/busy model,
// per-port expected-data queues, one task per scenario.
module tb_risc_register_file;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;

   logic                clk;
   logic                reset;
   logic [ADDR_W-1:0]   rd_addr_a, rd_addr_b;
   logic                rd_addr_a_valid, rd_addr_b_valid;
   logic [XLEN-1:0]     rd_data_a, rd_data_b;
   logic                rd_data_a_ack, rd_data_b_ack;
   logic [ADDR_W-1:0]   wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_valid;
   logic [ADDR_W-1:0]   reserve_addr;
   logic                reserve_valid;
   logic [NUM_REGS-1:0] busy_vec;
   logic [1:0]          rf_state_dbg;

   int errors = 0;
   int checks = 0;

   logic [XLEN-1:0]     exp_a_q[$];
   logic [XLEN-1:0]     exp_b_q[$];
   logic [XLEN-1:0]     m_regs[NUM_REGS];
   logic [NUM_REGS-1:0] m_busy;
   logic [XLEN-1:0]     last_a, last_b;

   int stall_cnt = 0;

   risc_register_file #(
      .XLEN (XLEN), .NUM_REGS (NUM_REGS), .ADDR_W (ADDR_W)
   ) dut (
      .clk (clk), .reset (reset),
      .rd_addr_a (rd_addr_a), .rd_addr_a_valid (rd_addr_a_valid),
      .rd_data_a (rd_data_a), .rd_data_a_ack (rd_data_a_ack),
      .rd_addr_b (rd_addr_b), .rd_addr_b_valid (rd_addr_b_valid),
      .rd_data_b (rd_data_b), .rd_data_b_ack (rd_data_b_ack),
      .wr_addr (wr_addr), .wr_data (wr_data), .wr_valid (wr_valid),
      .reserve_addr (reserve_addr), .reserve_valid (reserve_valid),
      .busy_vec (busy_vec), .rf_state_dbg (rf_state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A stall with no matching write is a protocol error.
   always @(posedge clk) begin
      if (rf_state_dbg == 2'd1) stall_cnt = stall_cnt + 1;
      else stall_cnt = 0;
      assert (stall_cnt <= 64) else begin
         $display("FAIL stall_timeout got=%0d cycles exp<=64", stall_cnt);
         errors++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      rd_addr_a = '0; rd_addr_a_valid = 1'b0;
      rd_addr_b = '0; rd_addr_b_valid = 1'b0;
      wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
      reserve_addr = '0; reserve_valid = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      m_busy = '0;
      last_a = '0;
      last_b = '0;
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
      wr_addr = a; wr_data = d; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      if (a != 0) begin
         m_regs[a] = d;
         m_busy[a] = 1'b0;
      end
   endtask

   task automatic do_reserve(input logic [ADDR_W-1:0] a);
      reserve_addr = a; reserve_valid = 1'b1;
      tick();
      reserve_valid = 1'b0;
      if (a != 0) m_busy[a] = 1'b1;
   endtask

   task automatic start_req(input logic va, input logic [ADDR_W-1:0] aa,
                            input logic vb, input logic [ADDR_W-1:0] ab);
      rd_addr_a = aa; rd_addr_a_valid = va;
      rd_addr_b = ab; rd_addr_b_valid = vb;
   endtask

   // Waits for an ack (bounded), captures it, drops valids and steps past the ack cycle.
   task automatic wait_ack(input int budget, output int cyc, output logic sa, output logic sb,
                           output logic [XLEN-1:0] da, output logic [XLEN-1:0] db,
                           output logic after);
      cyc = 0;
      while (!(rd_data_a_ack || rd_data_b_ack) && cyc < budget) begin
         tick();
         cyc++;
      end
      sa = rd_data_a_ack; sb = rd_data_b_ack;
      da = rd_data_a;     db = rd_data_b;
      rd_addr_a_valid = 1'b0;
      rd_addr_b_valid = 1'b0;
      tick();
      after = rd_data_a_ack | rd_data_b_ack;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset(3);
      checks++; if (rd_data_a_ack !== 1'b0 || rd_data_b_ack !== 1'b0) begin
         errors++; $display("FAIL reset_acks got=%b%b exp=00", rd_data_a_ack, rd_data_b_ack); end
      checks++; if (rd_data_a !== '0 || rd_data_b !== '0) begin
         errors++; $display("FAIL reset_data got=%h/%h exp=0/0", rd_data_a, rd_data_b); end
      checks++; if (busy_vec !== '0) begin
         errors++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
      checks++; if (rf_state_dbg !== 2'd0) begin
         errors++; $display("FAIL reset_state got=%0d exp=0", rf_state_dbg); end
   endtask

   task automatic test_basic_read();
      int cyc; logic sa, sb, aft; logic [XLEN-1:0] da, db, ea, eb;
      do_write(5'd5, 32'h0000_1234);
      exp_a_q.push_back(m_regs[5]);
      exp_b_q.push_back(32'h0);
      start_req(1'b1, 5'd5, 1'b1, 5'd0);
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (cyc !== 1 || sa !== 1'b1 || sb !== 1'b1) begin
         errors++; $display("FAIL basic_ack got=lat%0d a%b b%b exp=lat1 a1 b1", cyc, sa, sb); end
      checks++; if (da !== ea || db !== eb) begin
         errors++; $display("FAIL basic_data got=%h/%h exp=%h/%h", da, db, ea, eb); end
      checks++; if (aft !== 1'b0) begin
         errors++; $display("FAIL basic_ack_pulse got=%b exp=0", aft); end
      last_a = ea; last_b = eb;
   endtask

   task automatic test_x0();
      int cyc; logic sa, sb, aft; logic [XLEN-1:0] da, db, ea;
      do_write(5'd0, 32'hFFFF_FFFF);
      do_reserve(5'd0);
      checks++; if (busy_vec[0] !== 1'b0) begin
         errors++; $display("FAIL x0_busy got=%b exp=0", busy_vec[0]); end
      exp_a_q.push_back(32'h0);
      start_req(1'b1, 5'd0, 1'b0, 5'd0);
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front();
      checks++; if (sa !== 1'b1 || sb !== 1'b0 || da !== ea) begin
         errors++; $display("FAIL x0_read got=a%b b%b %h exp=a1 b0 %h", sa, sb, da, ea); end
      checks++; if (db !== last_b) begin
         errors++; $display("FAIL x0_b_held got=%h exp=%h", db, last_b); end
      last_a = ea;
   endtask

   task automatic test_stall();
      int cyc; logic sa, sb, aft, early; logic [XLEN-1:0] da, db, ea, eb;
      do_write(5'd3, 32'h55);
      do_reserve(5'd7);
      checks++; if (busy_vec !== m_busy) begin
         errors++; $display("FAIL stall_busy_set got=%h exp=%h", busy_vec, m_busy); end
      start_req(1'b1, 5'd7, 1'b1, 5'd3);
      early = 1'b0;
      repeat (3) begin
         tick();
         if (rd_data_a_ack || rd_data_b_ack) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin
         errors++; $display("FAIL stall_early_ack got=%b exp=0", early); end
      do_write(5'd7, 32'h0000_ABCD);
      exp_a_q.push_back(m_regs[7]);
      exp_b_q.push_back(m_regs[3]);
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (cyc !== 0 || sa !== 1'b1 || sb !== 1'b1) begin
         errors++; $display("FAIL stall_ack got=lat%0d a%b b%b exp=lat0 a1 b1", cyc, sa, sb); end
      checks++; if (da !== ea || db !== eb) begin
         errors++; $display("FAIL stall_data got=%h/%h exp=%h/%h", da, db, ea, eb); end
      checks++; if (busy_vec !== m_busy) begin
         errors++; $display("FAIL stall_busy_clr got=%h exp=%h", busy_vec, m_busy); end
      last_a = ea; last_b = eb;
   endtask

   task automatic test_same_edge_bypass();
      int cyc; logic sa, sb, aft; logic [XLEN-1:0] da, db, ea;
      do_reserve(5'd9);
      start_req(1'b1, 5'd9, 1'b0, 5'd0);
      do_write(5'd9, 32'h77);
      exp_a_q.push_back(32'h77);
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front();
      checks++; if (cyc !== 0 || sa !== 1'b1 || sb !== 1'b0) begin
         errors++; $display("FAIL bypass_ack got=lat%0d a%b b%b exp=lat0 a1 b0", cyc, sa, sb); end
      checks++; if (da !== ea || db !== last_b) begin
         errors++; $display("FAIL bypass_data got=%h/%h exp=%h/%h", da, db, ea, last_b); end
      last_a = ea;
   endtask

   task automatic test_reserve_write_same_edge();
      int cyc; logic sa, sb, aft, early; logic [XLEN-1:0] da, db, ea;
      wr_addr = 5'd4; wr_data = 32'h11; wr_valid = 1'b1;
      reserve_addr = 5'd4; reserve_valid = 1'b1;
      tick();
      wr_valid = 1'b0; reserve_valid = 1'b0;
      m_regs[4] = 32'h11; m_busy[4] = 1'b1;
      checks++; if (busy_vec[4] !== 1'b1) begin
         errors++; $display("FAIL rsv_wr_busy got=%b exp=1", busy_vec[4]); end
      start_req(1'b1, 5'd4, 1'b0, 5'd0);
      early = 1'b0;
      repeat (2) begin
         tick();
         if (rd_data_a_ack || rd_data_b_ack) early = 1'b1;
      end
      checks++; if (early !== 1'b0) begin
         errors++; $display("FAIL rsv_wr_early_ack got=%b exp=0", early); end
      do_write(5'd4, 32'h22);
      exp_a_q.push_back(m_regs[4]);
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front();
      checks++; if (cyc !== 0 || sa !== 1'b1 || da !== ea) begin
         errors++; $display("FAIL rsv_wr_read got=lat%0d a%b %h exp=lat0 a1 %h", cyc, sa, da, ea); end
      last_a = ea;
   endtask

   task automatic test_reserve_same_edge_request();
      int cyc; logic sa, sb, aft; logic [XLEN-1:0] da, db, ea;
      do_write(5'd12, 32'hC0DE_0012);
      start_req(1'b1, 5'd12, 1'b0, 5'd0);
      reserve_addr = 5'd12; reserve_valid = 1'b1;
      exp_a_q.push_back(m_regs[12]);
      tick();
      reserve_valid = 1'b0;
      m_busy[12] = 1'b1;
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front();
      checks++; if (cyc !== 0 || sa !== 1'b1 || da !== ea) begin
         errors++; $display("FAIL rsv_req_old_busy got=lat%0d a%b %h exp=lat0 a1 %h", cyc, sa, da, ea); end
      checks++; if (busy_vec !== m_busy) begin
         errors++; $display("FAIL rsv_req_busy got=%h exp=%h", busy_vec, m_busy); end
      last_a = ea;
      do_write(5'd12, $urandom());
   endtask

   task automatic test_back_to_back();
      int cyc; logic sa, sb, aft; logic [XLEN-1:0] da, db, ea, eb;
      logic [ADDR_W-1:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = ADDR_W'($urandom_range(13, 31));
         do_write(a, $urandom());
      end
      for (int i = 0; i < 8; i++) begin
         a = ADDR_W'($urandom_range(0, 31));
         b = ADDR_W'($urandom_range(0, 31));
         exp_a_q.push_back(m_regs[a]);
         exp_b_q.push_back(m_regs[b]);
         start_req(1'b1, a, 1'b1, b);
         wait_ack(10, cyc, sa, sb, da, db, aft);
         ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
         checks++; if (cyc !== 1 || sa !== 1'b1 || sb !== 1'b1 || da !== ea || db !== eb) begin
            errors++;
            $display("FAIL b2b_%0d got=lat%0d a%b b%b %h/%h exp=lat1 a1 b1 %h/%h",
                     i, cyc, sa, sb, da, db, ea, eb);
         end
         last_a = ea; last_b = eb;
      end
   endtask

   task automatic test_reset_in_stall();
      int cyc; logic sa, sb, aft, late; logic [XLEN-1:0] da, db, ea, eb;
      do_reserve(5'd10);
      start_req(1'b1, 5'd10, 1'b0, 5'd0);
      repeat (2) tick();
      checks++; if (rf_state_dbg !== 2'd1) begin
         errors++; $display("FAIL rst_stall_state got=%0d exp=1", rf_state_dbg); end
      reset = 1'b1;
      rd_addr_a_valid = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
      late = 1'b0;
      repeat (4) begin
         tick();
         if (rd_data_a_ack || rd_data_b_ack) late = 1'b1;
      end
      checks++; if (late !== 1'b0 || busy_vec !== '0) begin
         errors++; $display("FAIL rst_stall_quiet got=ack%b busy%h exp=ack0 busy0", late, busy_vec); end
      exp_a_q.push_back(m_regs[5]);
      exp_b_q.push_back(m_regs[3]);
      start_req(1'b1, 5'd5, 1'b1, 5'd3);
      wait_ack(10, cyc, sa, sb, da, db, aft);
      ea = exp_a_q.pop_front(); eb = exp_b_q.pop_front();
      checks++; if (sa !== 1'b1 || sb !== 1'b1 || da !== ea || db !== eb) begin
         errors++; $display("FAIL rst_regs_zero got=a%b b%b %h/%h exp=a1 b1 %h/%h",
                            sa, sb, da, db, ea, eb); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      init_inputs();
      reset = 1'b1;
      model_reset();
      test_reset();
      test_basic_read();
      test_x0();
      test_stall();
      test_same_edge_bypass();
      test_reserve_write_same_edge();
      test_reserve_same_edge_request();
      test_back_to_back();
      test_reset_in_stall();
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog got=timeout exp=completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
